// File: rtl/dcache_pkg.sv
// Shared types and field-width helpers for the write-back data cache.
package dcache_pkg;

  // Controller states
  typedef enum logic [1:0] {
    S_IDLE      = 2'd0,
    S_WRITEBACK = 2'd1,
    S_REFILL    = 2'd2
  } state_t;

  // Tag storage is sized for the widest supported address; unused upper
  // bits always hold zero so a full-width compare is still exact.
  localparam int TAG_MAX_W = 32;

  typedef struct packed {
    logic                 valid;
    logic                 dirty;
    logic [TAG_MAX_W-1:0] tag;
  } line_meta_t;

  function automatic int off_width(input int words_per_block);
    return $clog2(words_per_block);
  endfunction

  function automatic int idx_width(input int num_lines);
    return $clog2(num_lines);
  endfunction

  function automatic int tag_width(input int addr_w, input int words_per_block,
                                   input int num_lines);
    return addr_w - $clog2(words_per_block) - $clog2(num_lines);
  endfunction

endpackage

// File: rtl/dcache_backing_mem.sv
// Word-addressed backing store with single-cycle whole-block ports.
// Combinational block read, block write at the clock edge. The array has no
// reset (contents survive rst) and relies on zero power-up contents.
module dcache_backing_mem
  import dcache_pkg::*;
#(
  parameter int ADDR_W          = 10,
  parameter int WORDS_PER_BLOCK = 4
) (
  input  logic                                    clk,
  input  logic                                    i_we,
  input  logic [ADDR_W-off_width(WORDS_PER_BLOCK)-1:0] i_wr_blk,
  input  logic [WORDS_PER_BLOCK*32-1:0]           i_wr_data,
  input  logic [ADDR_W-off_width(WORDS_PER_BLOCK)-1:0] i_rd_blk,
  output logic [WORDS_PER_BLOCK*32-1:0]           o_rd_data
);
  localparam int OFF_W = off_width(WORDS_PER_BLOCK);

  logic [31:0] r_mem [2**ADDR_W];

  // Block write: every word of the block lands in the same cycle
  always_ff @(posedge clk) begin
    if (i_we) begin
      for (int w = 0; w < WORDS_PER_BLOCK; w++) begin
        r_mem[{i_wr_blk, OFF_W'(w)}] <= i_wr_data[w*32 +: 32];
      end
    end
  end

  for (genvar g = 0; g < WORDS_PER_BLOCK; g++) begin : g_rd
    assign o_rd_data[g*32 +: 32] = r_mem[{i_rd_blk, OFF_W'(g)}];
  end

endmodule

// File: rtl/dcache_wb_system.sv
// Direct-mapped write-back / write-allocate data cache with backing memory.
// Optional build macro DCACHE_PERF_CNT_EN adds saturating access, miss and
// writeback counters as extra outputs.
//
// state       | meaning
// S_IDLE      | serving hits; a miss latches index/tag and leaves
// S_WRITEBACK | waiting MEM_LATENCY cycles, dirty victim written on last
// S_REFILL    | waiting MEM_LATENCY cycles, block loaded on last
module dcache_wb_system
  import dcache_pkg::*;
#(
  parameter int ADDR_W          = 10,
  parameter int WORDS_PER_BLOCK = 4,
  parameter int NUM_LINES       = 32,
  parameter int MEM_LATENCY     = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              mem_read,
  input  logic              mem_write,
  input  logic [ADDR_W-1:0] word_address,
  input  logic [31:0]       data_in,
  output logic              stall,
  output logic [31:0]       data_out
`ifdef DCACHE_PERF_CNT_EN
  ,
  output logic [31:0]       access_count,
  output logic [31:0]       miss_count,
  output logic [31:0]       writeback_count
`endif
);
  localparam int OFF_W = off_width(WORDS_PER_BLOCK);
  localparam int IDX_W = idx_width(NUM_LINES);
  localparam int TAG_W = tag_width(ADDR_W, WORDS_PER_BLOCK, NUM_LINES);
  localparam int BLK_W = WORDS_PER_BLOCK * 32;
  localparam int BA_W  = ADDR_W - OFF_W;
  localparam int CNT_W = $clog2(MEM_LATENCY + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MEM_LATENCY - 1);

  state_t           r_state, w_state_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic [IDX_W-1:0] r_idx;
  logic [TAG_W-1:0] r_tag;
  line_meta_t       r_meta [NUM_LINES];
  logic [BLK_W-1:0] r_data [NUM_LINES];

  logic [OFF_W-1:0] w_off;
  logic [IDX_W-1:0] w_idx;
  logic [TAG_W-1:0] w_tag;
  logic             w_req, w_hit, w_idle, w_last, w_victim_dirty;
  logic             w_wb_done, w_fill_done, w_wr_hit;
  logic [BLK_W-1:0] w_fill_block;
  logic [BA_W-1:0]  w_wb_blk, w_fill_blk;

  assign w_off  = word_address[OFF_W-1:0];
  assign w_idx  = word_address[OFF_W +: IDX_W];
  assign w_tag  = word_address[ADDR_W-1 -: TAG_W];
  assign w_req  = mem_read | mem_write;
  assign w_hit  = r_meta[w_idx].valid && (r_meta[w_idx].tag == TAG_MAX_W'(w_tag));
  assign w_idle = (r_state == S_IDLE);
  assign w_last = (r_cnt == CNT_LAST);
  assign w_victim_dirty = r_meta[w_idx].valid & r_meta[w_idx].dirty;

  assign w_wb_done   = (r_state == S_WRITEBACK) && w_last;
  assign w_fill_done = (r_state == S_REFILL) && w_last;
  assign w_wr_hit    = w_idle && mem_write && w_hit;

  assign w_wb_blk   = {r_meta[r_idx].tag[TAG_W-1:0], r_idx};
  assign w_fill_blk = {r_tag, r_idx};

  dcache_backing_mem #(
    .ADDR_W          (ADDR_W),
    .WORDS_PER_BLOCK (WORDS_PER_BLOCK)
  ) u_mem (
    .clk       (clk),
    .i_we      (w_wb_done),
    .i_wr_blk  (w_wb_blk),
    .i_wr_data (r_data[r_idx]),
    .i_rd_blk  (w_fill_blk),
    .o_rd_data (w_fill_block)
  );

  // Next state and requester-facing outputs; rst forces both outputs quiet
  always_comb begin
    w_state_nxt = r_state;
    stall       = 1'b0;
    data_out    = '0;
    unique case (r_state)
      S_IDLE:      if (w_req && !w_hit) w_state_nxt = w_victim_dirty ? S_WRITEBACK : S_REFILL;
      S_WRITEBACK: if (w_last) w_state_nxt = S_REFILL;
      S_REFILL:    if (w_last) w_state_nxt = S_IDLE;
      default:     w_state_nxt = S_IDLE;
    endcase
    if (!rst) begin
      stall = !w_idle || (w_req && !w_hit);
      if (w_idle && mem_read && !mem_write && w_hit)
        data_out = r_data[w_idx][{w_off, 5'd0} +: 32];
    end
  end

  // State register, latency counter and latched miss address
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_idx   <= '0;
      r_tag   <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_idle || (w_state_nxt != r_state)) r_cnt <= '0;
      else                                    r_cnt <= r_cnt + 1'b1;
      if (w_idle && w_req && !w_hit) begin
        r_idx <= w_idx;
        r_tag <= w_tag;
      end
    end
  end

  // Line metadata: reset invalidates everything, dirty victims are dropped
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_LINES; i++) r_meta[i] <= '0;
    end else if (w_fill_done) begin
      r_meta[r_idx] <= '{valid: 1'b1, dirty: 1'b0, tag: TAG_MAX_W'(r_tag)};
    end else if (w_wr_hit) begin
      r_meta[w_idx].dirty <= 1'b1;
    end
  end

  // Line data: refill loads the whole block, write hits patch one word
  always_ff @(posedge clk) begin
    if (w_fill_done)   r_data[r_idx] <= w_fill_block;
    else if (w_wr_hit) r_data[w_idx][{w_off, 5'd0} +: 32] <= data_in;
  end

`ifdef DCACHE_PERF_CNT_EN
  logic [31:0] r_access_cnt, r_miss_cnt, r_wb_cnt;

  // Saturating performance counters
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_access_cnt <= '0;
      r_miss_cnt   <= '0;
      r_wb_cnt     <= '0;
    end else begin
      if (w_req && !stall && (r_access_cnt != '1)) r_access_cnt <= r_access_cnt + 32'd1;
      if (w_idle && (w_state_nxt != S_IDLE) && (r_miss_cnt != '1)) r_miss_cnt <= r_miss_cnt + 32'd1;
      if (w_wb_done && (r_wb_cnt != '1)) r_wb_cnt <= r_wb_cnt + 32'd1;
    end
  end

  assign access_count    = r_access_cnt;
  assign miss_count      = r_miss_cnt;
  assign writeback_count = r_wb_cnt;
`endif

endmodule

// File: tb/tb_dcache_wb_system.sv
// Scoreboard bench for dcache_wb_system: the driver predicts each access's
// stall length and read data from an architectural memory model, the monitor
// checks them when the DUT drops stall.
`timescale 1ns/1ps
module tb_dcache_wb_system;
  localparam int ADDR_W = 10;
  localparam int WPB    = 4;
  localparam int NL     = 32;
  localparam int LAT    = 4;
  localparam int MEMSZ  = 1 << ADDR_W;

  logic              clk = 1'b0;
  logic              rst;
  logic              mem_read, mem_write;
  logic [ADDR_W-1:0] word_address;
  logic [31:0]       data_in;
  logic              stall;
  logic [31:0]       data_out;
`ifdef DCACHE_PERF_CNT_EN
  logic [31:0]       access_count, miss_count, writeback_count;
`endif

  dcache_wb_system #(
    .ADDR_W(ADDR_W), .WORDS_PER_BLOCK(WPB), .NUM_LINES(NL), .MEM_LATENCY(LAT)
  ) dut (
    .clk(clk), .rst(rst), .mem_read(mem_read), .mem_write(mem_write),
    .word_address(word_address), .data_in(data_in),
    .stall(stall), .data_out(data_out)
`ifdef DCACHE_PERF_CNT_EN
    , .access_count(access_count), .miss_count(miss_count),
    .writeback_count(writeback_count)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    int          addr;
    logic [31:0] exp_data;
    int          exp_stall;
  } exp_t;

  exp_t sb[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  bit   mon_en  = 0;
  int   stall_run = 0;

  // Reference model: arch = value a program would read, backing = memory
  // contents; the cache is described only by which block each index holds.
  logic [31:0] arch    [MEMSZ];
  logic [31:0] backing [MEMSZ];
  bit          m_valid [NL];
  bit          m_dirty [NL];
  int          m_tag   [NL];
  int          m_acc, m_miss, m_wb;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  function automatic int blk_base(input int tag, input int idx);
    return tag * (NL * WPB) + idx * WPB;
  endfunction

  // Reset drops cached lines; dirty data never reached memory and is lost
  task automatic model_reset();
    for (int i = 0; i < NL; i++) begin
      if (m_valid[i] && m_dirty[i])
        for (int w = 0; w < WPB; w++)
          arch[blk_base(m_tag[i], i) + w] = backing[blk_base(m_tag[i], i) + w];
      m_valid[i] = 0;
      m_dirty[i] = 0;
    end
    m_acc = 0; m_miss = 0; m_wb = 0;
  endtask

  task automatic reset_pulse();
    mon_en = 0;
    mem_read = 0; mem_write = 0;
    rst = 1;
    @(posedge clk); #1;
    rst = 0;
    model_reset();
    stall_run = 0;
    mon_en = 1;
  endtask

  // Predict, push expectation, drive and hold until the DUT accepts
  task automatic access(input bit we, input int addr, input logic [31:0] d);
    int   idx, tag, st;
    bit   hit;
    exp_t e;
    idx = (addr / WPB) % NL;
    tag = addr / (WPB * NL);
    hit = m_valid[idx] && (m_tag[idx] == tag);
    if (hit) st = 0;
    else if (m_valid[idx] && m_dirty[idx]) st = 1 + 2 * LAT;
    else st = 1 + LAT;
    if (!hit) begin
      m_miss++;
      if (m_valid[idx] && m_dirty[idx]) begin
        m_wb++;
        for (int w = 0; w < WPB; w++)
          backing[blk_base(m_tag[idx], idx) + w] = arch[blk_base(m_tag[idx], idx) + w];
      end
      m_valid[idx] = 1; m_dirty[idx] = 0; m_tag[idx] = tag;
    end
    if (we) begin
      arch[addr] = d;
      m_dirty[idx] = 1;
    end
    m_acc++;
    e.addr = addr;
    e.exp_data = we ? 32'h0 : arch[addr];
    e.exp_stall = st;
    sb.push_back(e);

    mem_write = we;
    mem_read = we ? 1'($urandom_range(0, 1)) : 1'b1;
    word_address = ADDR_W'(addr);
    data_in = d;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (!stall) break;
    end
    if (stall) begin
      n_fail++;
      $display("FAIL timeout: stall stuck at addr 0x%03h", addr);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $fatal(1, "stall never released");
    end
    @(posedge clk); #1;
    mem_read = 0; mem_write = 0;
    if ($urandom_range(0, 2) == 0) begin
      @(posedge clk); #1;
    end
  endtask

  function automatic int rand_addr();
    if ($urandom_range(0, 3) == 0) return int'($urandom_range(0, MEMSZ - 1));
    return int'($urandom_range(0, 7)) * (WPB * NL) + int'($urandom_range(0, 3)) * WPB
           + int'($urandom_range(0, WPB - 1));
  endfunction

  task automatic random_phase(input int n);
    for (int i = 0; i < n; i++) begin
      if ($urandom_range(0, 1) == 1) access(1, rand_addr(), $urandom());
      else                           access(0, rand_addr(), 32'h0);
    end
  endtask

  // Monitor: completes an access on the first non-stalled cycle
  always @(negedge clk) begin
    exp_t e;
    if (mon_en) begin
      if (mem_read || mem_write) begin
        if (stall) stall_run++;
        else begin
          if (sb.size() == 0) check("sb_underflow", 32'd1, 32'd0);
          else begin
            e = sb.pop_front();
            check($sformatf("data@%03h", e.addr), data_out, e.exp_data);
            check($sformatf("stall_cycles@%03h", e.addr), stall_run, e.exp_stall);
          end
          stall_run = 0;
        end
      end else begin
        check("idle_stall", {31'd0, stall}, 32'd0);
        check("idle_data", data_out, 32'd0);
      end
    end
  end

  initial begin
    rst = 1; mem_read = 0; mem_write = 0; word_address = '0; data_in = '0;
    for (int i = 0; i < MEMSZ; i++) begin arch[i] = 0; backing[i] = 0; end
    model_reset();
    #1;
    check("reset_stall", {31'd0, stall}, 32'd0);
    check("reset_data", data_out, 32'd0);
    @(posedge clk); #1;
    reset_pulse();

    // Directed sequence: clean miss, write hit, dirty eviction, write miss
    access(0, 'h004, 32'h0);
    access(1, 'h005, 32'hDEADBEEF);
    access(0, 'h005, 32'h0);
    access(0, 'h085, 32'h0);
    access(0, 'h005, 32'h0);
    access(1, 'h3FF, 32'h12345678);
    access(0, 'h3FF, 32'h0);

    random_phase(300);

    // Reset in the second REFILL cycle of a read miss on 0x004
    reset_pulse();
    mon_en = 0;
    mem_read = 1; word_address = 'h004;
    @(posedge clk);
    @(posedge clk); #1;
    check("pre_rst_stall", {31'd0, stall}, 32'd1);
    rst = 1; #1;
    check("rst_mid_stall", {31'd0, stall}, 32'd0);
    check("rst_mid_data", data_out, 32'd0);
    @(posedge clk); #1;
    mem_read = 0;
    rst = 0;
    model_reset();
    stall_run = 0;
    mon_en = 1;
    access(0, 'h004, 32'h0);

    random_phase(200);

`ifdef DCACHE_PERF_CNT_EN
    #1;
    check("access_count", access_count, 32'(m_acc));
    check("miss_count", miss_count, 32'(m_miss));
    check("writeback_count", writeback_count, 32'(m_wb));
    force dut.r_miss_cnt = 32'hFFFFFFFF;
    @(posedge clk); #1;
    release dut.r_miss_cnt;
    begin
      int a;
      a = 'h3FC;
      if (m_valid[31] && m_tag[31] == 7) a = 'h07C;
      access(0, a, 32'h0);
    end
    check("miss_count_sat", miss_count, 32'hFFFFFFFF);
`endif

    @(negedge clk);
    check("sb_drained", 32'(sb.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
